seg_page_scheduler: RTL and testbench

- Decides what the 4-digit 7-segment display shows and passes four glyph codes to the digit-scan FSM downstream.
- Rotates between a Player-1 score page and a Player-2 score page.
- A one-shot message request (e.g. "PLAY") pre-empts the rotation for a fixed hold time, then acknowledges the requester.

---
 rtl/seg_page_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_seg_page_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_page_scheduler.sv
// seg_page_scheduler
// Chooses what the 4-digit 7-segment display shows. It alternates between a
// Player-1 and a Player-2 score page. A message request pre-empts the rotation
// for a fixed hold time and then acknowledges the requester.
// Optional build macro: SEG_LEAD_BLANK_EN blanks the tens digit of scores
// below 10 on the score pages.
// Glyph codes are active-low gfedcba, with the leftmost digit in [27:21].

module seg_page_scheduler #(
    parameter int PAGE_CYCLES = 1024,
    parameter int MSG_CYCLES  = 2048,
    parameter int TW          = 12
) (
    input  logic        segclk,
    input  logic        clr,
    input  logic [6:0]  p1_score,
    input  logic [6:0]  p2_score,
    input  logic        msg_req,
    input  logic [27:0] msg_glyphs,
    output logic        msg_ack,
    output logic [27:0] glyphs,
    output logic [1:0]  page_id
);

    typedef enum logic [1:0] {
        S_P1  = 2'b00,
        S_P2  = 2'b01,
        S_MSG = 2'b10
    } state_t;

    localparam logic [TW-1:0] PAGE_LAST = TW'(PAGE_CYCLES - 1);
    localparam logic [TW-1:0] MSG_LAST  = TW'(MSG_CYCLES - 1);

    localparam logic [6:0]  GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0]  GLYPH_P     = 7'b0001100;
    localparam logic [6:0]  GLYPH_ONE   = 7'b1111001;
    localparam logic [6:0]  GLYPH_TWO   = 7'b0100100;
    localparam logic [27:0] PAGE_BLANK  = {4{GLYPH_BLANK}};

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [27:0]   msg_latch, latch_nxt;
    logic          ret_p2, ret_nxt;
    logic          ack_nxt;
    logic [27:0]   glyphs_nxt;
    logic [1:0]    page_nxt;
    logic [27:0]   p1_page, p2_page;

    // Decimal digit to active-low gfedcba code.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    // Builds one score page "P<n><tens><units>". Scores above 99 saturate so the
    // display never needs a third digit.
    function automatic logic [27:0] score_page(input logic [6:0] score,
                                               input logic       player2);
        logic [6:0] sat;
        logic [3:0] tens;
        logic [3:0] units;
        logic [6:0] tens_g;
        sat    = (score > 7'd99) ? 7'd99 : score;
        tens   = 4'(sat / 7'd10);
        units  = 4'(sat % 7'd10);
        tens_g = seg_digit(tens);
`ifdef SEG_LEAD_BLANK_EN
        if (sat < 7'd10) tens_g = GLYPH_BLANK;
`else
        tens_g = seg_digit(tens);
`endif
        return {GLYPH_P, (player2 ? GLYPH_TWO : GLYPH_ONE), tens_g, seg_digit(units)};
    endfunction

    // State, timer, message latch, return page and ack pulse registers.
    always_ff @(posedge segclk or negedge clr) begin
        if (!clr) begin
            state     <= S_P1;
            timer     <= '0;
            msg_latch <= PAGE_BLANK;
            ret_p2    <= 1'b0;
            msg_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            msg_latch <= latch_nxt;
            ret_p2    <= ret_nxt;
            msg_ack   <= ack_nxt;
        end
    end

    // Next-state logic. A request wins over page rotation, and the request is
    // masked during the ack cycle so a held request produces a fresh grant
    // one cycle later instead of a grant on the same cycle as the ack.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer + TW'(1);
        latch_nxt = msg_latch;
        ret_nxt   = ret_p2;
        ack_nxt   = 1'b0;
        case (state)
            S_P1, S_P2: begin
                if (msg_req && !msg_ack) begin
                    state_nxt = S_MSG;
                    timer_nxt = '0;
                    latch_nxt = msg_glyphs;
                    ret_nxt   = (state == S_P2);
                end else if (timer == PAGE_LAST) begin
                    state_nxt = (state == S_P1) ? S_P2 : S_P1;
                    timer_nxt = '0;
                end
            end
            S_MSG: begin
                if (timer == MSG_LAST) begin
                    ack_nxt   = 1'b1;
                    state_nxt = ret_p2 ? S_P2 : S_P1;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_P1;
                timer_nxt = '0;
            end
        endcase
    end

    // Score pages are built from the live scores every cycle.
    always_comb begin
        p1_page = score_page(p1_score, 1'b0);
        p2_page = score_page(p2_score, 1'b1);
    end

    // Selects the content for the current state. It is registered below, so
    // the display lags the state by one cycle.
    always_comb begin
        glyphs_nxt = p1_page;
        page_nxt   = 2'b00;
        case (state)
            S_P1: begin
                glyphs_nxt = p1_page;
                page_nxt   = 2'b00;
            end
            S_P2: begin
                glyphs_nxt = p2_page;
                page_nxt   = 2'b01;
            end
            S_MSG: begin
                glyphs_nxt = msg_latch;
                page_nxt   = 2'b10;
            end
            default: begin
                glyphs_nxt = PAGE_BLANK;
                page_nxt   = 2'b00;
            end
        endcase
    end

    // Output registers that feed the digit-scan FSM. They show a blank display
    // while reset is asserted.
    always_ff @(posedge segclk or negedge clr) begin
        if (!clr) begin
            glyphs  <= PAGE_BLANK;
            page_id <= 2'b00;
        end else begin
            glyphs  <= glyphs_nxt;
            page_id <= page_nxt;
        end
    end

endmodule

// File: tb/tb_seg_page_scheduler.sv
// tb_seg_page_scheduler
// Directed bench for seg_page_scheduler. The design runs with short page and
// message periods. The expected glyphs are hand-built constants.
// The bench honours SEG_LEAD_BLANK_EN in the same way as the design.

module tb_seg_page_scheduler;

    localparam int PAGE = 8;
    localparam int MSG  = 12;

    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GP = 7'b0001100;
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GL = 7'b1000111;
    localparam logic [6:0] GA = 7'b0001000;
`ifdef SEG_LEAD_BLANK_EN
    localparam logic [6:0] GZ = GB;
`else
    localparam logic [6:0] GZ = G0;
`endif

    localparam logic [27:0] BLANK_PAGE = {GB, GB, GB, GB};
    localparam logic [27:0] P1_42      = {GP, G1, G4, G2};
    localparam logic [27:0] P2_07      = {GP, G2, GZ, G7};
    localparam logic [27:0] MSG_PLAY   = {GP, GL, GA, G1};

    logic        segclk;
    logic        clr;
    logic [6:0]  p1_score;
    logic [6:0]  p2_score;
    logic        msg_req;
    logic [27:0] msg_glyphs;
    logic        msg_ack;
    logic [27:0] glyphs;
    logic [1:0]  page_id;

    int vectors;
    int miscompares;
    int edge_n;

    seg_page_scheduler #(.PAGE_CYCLES(PAGE), .MSG_CYCLES(MSG), .TW(4)) dut (
        .segclk     (segclk),
        .clr        (clr),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .msg_req    (msg_req),
        .msg_glyphs (msg_glyphs),
        .msg_ack    (msg_ack),
        .glyphs     (glyphs),
        .page_id    (page_id)
    );

    initial segclk = 1'b0;
    always #5 segclk = ~segclk;

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge segclk);
        #1;
        edge_n++;
    endtask

    // Pulse reset, then release it on a falling edge. The edge numbering
    // restarts so that the next tick is edge 1.
    task automatic apply_reset();
        msg_req = 1'b0;
        clr = 1'b0;
        #1;
        @(negedge segclk);
        clr = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        msg_req = 1'b0;
        msg_glyphs = '0;
        p1_score = 7'd42;
        p2_score = 7'd7;
        #3 clr = 1'b0;
        #1;
        vectors++;
        if (glyphs !== BLANK_PAGE) begin
            miscompares++;
            $display("[TB] FAIL reset_glyphs got %h want %h", glyphs, BLANK_PAGE);
        end
        vectors++;
        if (page_id !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_page_id got %b want 00", page_id);
        end
        vectors++;
        if (msg_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_msg_ack got %b want 0", msg_ack);
        end
        @(negedge segclk);
        clr = 1'b1;
        edge_n = 0;
        tick();
        vectors++;
        if (glyphs !== P1_42 || page_id !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL first_edge_p1 got %h/%b want %h/00", glyphs, page_id, P1_42);
        end
        while (edge_n < PAGE) tick();
        vectors++;
        if (glyphs !== P1_42 || page_id !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL last_p1_edge got %h/%b want %h/00", glyphs, page_id, P1_42);
        end
        tick();
        vectors++;
        if (glyphs !== P2_07 || page_id !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rotate_p2 got %h/%b want %h/01", glyphs, page_id, P2_07);
        end
    endtask

    task automatic test_saturation();
        logic [6:0]  scores [5];
        logic [27:0] pages  [5];
        scores = '{7'd127, 7'd99, 7'd100, 7'd10, 7'd0};
        pages  = '{{GP, G1, G9, G9}, {GP, G1, G9, G9}, {GP, G1, G9, G9},
                   {GP, G1, G1, G0}, {GP, G1, GZ, G0}};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            p1_score = scores[i];
            tick();
            vectors++;
            if (glyphs !== pages[i]) begin
                miscompares++;
                $display("[TB] FAIL p1_score_%0d got %h want %h", scores[i], glyphs, pages[i]);
            end
        end
        p2_score = 7'd127;
        while (edge_n < PAGE + 1) tick();
        vectors++;
        if (glyphs !== {GP, G2, G9, G9} || page_id !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL p2_saturate got %h/%b want %h/01", glyphs, page_id, {GP, G2, G9, G9});
        end
        p1_score = 7'd42;
        p2_score = 7'd7;
    endtask

    task automatic test_message();
        logic [1:0] exp_pid;
        logic       exp_ack;
        apply_reset();
        while (edge_n < 10) tick();
        msg_req = 1'b1;
        msg_glyphs = MSG_PLAY;
        tick();
        msg_req = 1'b0;
        msg_glyphs = '0;
        vectors++;
        if (page_id !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL grant_edge_page_id got %b want 01", page_id);
        end
        for (int e = 12; e <= 32; e++) begin
            tick();
            exp_ack = (e == 11 + MSG);
            exp_pid = (e <= 11 + MSG) ? 2'b10 : (e <= 11 + MSG + PAGE) ? 2'b01 : 2'b00;
            vectors++;
            if (msg_ack !== exp_ack || page_id !== exp_pid) begin
                miscompares++;
                $display("[TB] FAIL msg_edge_%0d got ack=%b pid=%b want ack=%b pid=%b",
                         e, msg_ack, page_id, exp_ack, exp_pid);
            end
            if (e == 12) begin
                vectors++;
                if (glyphs !== MSG_PLAY) begin
                    miscompares++;
                    $display("[TB] FAIL msg_glyphs got %h want %h", glyphs, MSG_PLAY);
                end
            end
            if (e == 12 + MSG) begin
                vectors++;
                if (glyphs !== P2_07) begin
                    miscompares++;
                    $display("[TB] FAIL return_p2_glyphs got %h want %h", glyphs, P2_07);
                end
            end
        end
    endtask

    task automatic test_grant_at_terminal();
        logic [1:0] exp_pid;
        logic       exp_ack;
        apply_reset();
        while (edge_n < PAGE - 1) tick();
        msg_req = 1'b1;
        msg_glyphs = MSG_PLAY;
        tick();
        msg_req = 1'b0;
        for (int e = PAGE + 1; e <= PAGE + MSG + PAGE + 1; e++) begin
            tick();
            exp_ack = (e == PAGE + MSG);
            exp_pid = (e <= PAGE + MSG) ? 2'b10 : (e <= PAGE + MSG + PAGE) ? 2'b00 : 2'b01;
            vectors++;
            if (msg_ack !== exp_ack || page_id !== exp_pid) begin
                miscompares++;
                $display("[TB] FAIL term_edge_%0d got ack=%b pid=%b want ack=%b pid=%b",
                         e, msg_ack, page_id, exp_ack, exp_pid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_pid;
        logic       exp_ack;
        int         acks;
        acks = 0;
        apply_reset();
        tick();
        tick();
        msg_req = 1'b1;
        msg_glyphs = MSG_PLAY;
        tick();
        for (int e = 4; e <= 32; e++) begin
            tick();
            if (msg_ack === 1'b1) acks++;
            exp_ack = (e == 15) || (e == 29);
            exp_pid = (e == 16 || e == 17 || e == 30 || e == 31) ? 2'b00 : 2'b10;
            vectors++;
            if (msg_ack !== exp_ack || page_id !== exp_pid) begin
                miscompares++;
                $display("[TB] FAIL b2b_edge_%0d got ack=%b pid=%b want ack=%b pid=%b",
                         e, msg_ack, page_id, exp_ack, exp_pid);
            end
        end
        vectors++;
        if (acks != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_ack_count got %0d want 2", acks);
        end
        msg_req = 1'b0;
    endtask

    task automatic test_reset_mid_msg();
        int acks;
        acks = 0;
        apply_reset();
        tick();
        tick();
        msg_req = 1'b1;
        tick();
        msg_req = 1'b0;
        tick();
        tick();
        tick();
        #1 clr = 1'b0;
        #1;
        vectors++;
        if (glyphs !== BLANK_PAGE || page_id !== 2'b00 || msg_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_clr got %h/%b/%b want %h/00/0",
                     glyphs, page_id, msg_ack, BLANK_PAGE);
        end
        @(posedge segclk);
        @(negedge segclk);
        clr = 1'b1;
        edge_n = 0;
        tick();
        vectors++;
        if (glyphs !== P1_42 || page_id !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL clr_release_p1 got %h/%b want %h/00", glyphs, page_id, P1_42);
        end
        for (int e = 2; e <= 2 * MSG; e++) begin
            tick();
            if (msg_ack === 1'b1) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("[TB] FAIL clr_no_ack got %0d acks want 0", acks);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        edge_n = 0;
        test_reset();
        test_saturation();
        test_message();
        test_grant_at_terminal();
        test_back_to_back();
        test_reset_mid_msg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog in case the run stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

endmodule
